// File: rtl/axis_parity_checker.sv
// AXI-Stream parity checker: strips the trailing parity byte, flags bad packets on tuser/pkt_err.
// Optional saturating good/bad packet counters are enabled by defining PARITY_CHECKER_COUNTERS_EN.
module axis_parity_checker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             a_clk,
  input  logic             axis_aresetn,
  input  logic             axis_s_tvalid,
  input  logic [7:0]       axis_s_tdata,
  input  logic             axis_s_tlast,
  output logic             axis_s_tready,
  output logic             axis_m_tvalid,
  output logic [7:0]       axis_m_tdata,
  output logic             axis_m_tlast,
  output logic             axis_m_tuser,
  input  logic             axis_m_tready,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] acc_q, acc_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_last_q, m_last_d;
  logic       m_user_q, m_user_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       rdy_q;

  logic s_ready;
  logic accept;
  logic pkt_bad;

  // rdy_q keeps tready low until the first clock edge after reset release.
  assign s_ready = rdy_q & ((state_q == StIdle) | ~m_valid_q | axis_m_tready);
  assign accept  = axis_s_tvalid & s_ready;
  // A last beat arriving in StIdle is a runt and always counts as an error.
  assign pkt_bad = ((acc_q ^ axis_s_tdata) != 8'h00) | (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    acc_d     = acc_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    m_user_d  = m_user_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    if (m_valid_q && axis_m_tready) begin
      m_valid_d = 1'b0;
    end

    if (accept) begin
      acc_d  = axis_s_tlast ? 8'h00 : (acc_q ^ axis_s_tdata);
      done_d = axis_s_tlast;
      err_d  = axis_s_tlast & pkt_bad;
      unique case (state_q)
        StIdle: begin
          if (!axis_s_tlast) begin
            hold_d  = axis_s_tdata;
            state_d = StHold;
          end
        end
        StHold: begin
          m_valid_d = 1'b1;
          m_data_d  = hold_q;
          m_last_d  = axis_s_tlast;
          m_user_d  = axis_s_tlast & pkt_bad;
          if (axis_s_tlast) begin
            state_d = StIdle;
          end else begin
            hold_d = axis_s_tdata;
          end
        end
      endcase
    end
  end

  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state_q   <= StIdle;
      hold_q    <= 8'h00;
      acc_q     <= 8'h00;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'h00;
      m_last_q  <= 1'b0;
      m_user_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      acc_q     <= acc_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      m_user_q  <= m_user_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdy_q     <= 1'b1;
    end
  end

  assign axis_s_tready = s_ready;
  assign axis_m_tvalid = m_valid_q;
  assign axis_m_tdata  = m_data_q;
  assign axis_m_tlast  = m_last_q;
  assign axis_m_tuser  = m_user_q;
  assign pkt_done      = done_q;
  assign pkt_err       = err_q;

`ifdef PARITY_CHECKER_COUNTERS_EN
  logic [CNT_W-1:0] good_q, bad_q;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge a_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      good_q <= '0;
      bad_q  <= '0;
    end else if (done_d) begin
      if (err_d) begin
        if (bad_q != '1) bad_q <= bad_q + CntOne;
      end else begin
        if (good_q != '1) good_q <= good_q + CntOne;
      end
    end
  end

  assign good_cnt = good_q;
  assign bad_cnt  = bad_q;
`else
  assign good_cnt = '0;
  assign bad_cnt  = '0;
`endif

endmodule

// File: tb/tb_axis_parity_checker.sv
// Self-checking bench for axis_parity_checker: packet-level scoreboard plus directed literal checks.
module tb_axis_parity_checker;

`ifdef PARITY_CHECKER_COUNTERS_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tlast = 1'b0;
  logic        m_tready = 1'b1;
  logic        s_tready, m_tvalid, m_tlast, m_tuser, pkt_done, pkt_err;
  logic [7:0]  m_tdata;
  logic [15:0] good_cnt, bad_cnt;
  logic        s_tready4, m_tvalid4, m_tlast4, m_tuser4, pkt_done4, pkt_err4;
  logic [7:0]  m_tdata4;
  logic [3:0]  good_cnt4, bad_cnt4;

  always #5 clk = ~clk;

  axis_parity_checker #(.CNT_W(16)) dut (
    .a_clk(clk), .axis_aresetn(rst_n),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
    .axis_s_tready(s_tready),
    .axis_m_tvalid(m_tvalid), .axis_m_tdata(m_tdata), .axis_m_tlast(m_tlast),
    .axis_m_tuser(m_tuser), .axis_m_tready(m_tready),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  // Narrow-counter copy fed the same stream, used to observe saturation.
  axis_parity_checker #(.CNT_W(4)) dut4 (
    .a_clk(clk), .axis_aresetn(rst_n),
    .axis_s_tvalid(s_tvalid), .axis_s_tdata(s_tdata), .axis_s_tlast(s_tlast),
    .axis_s_tready(s_tready4),
    .axis_m_tvalid(m_tvalid4), .axis_m_tdata(m_tdata4), .axis_m_tlast(m_tlast4),
    .axis_m_tuser(m_tuser4), .axis_m_tready(m_tready),
    .pkt_done(pkt_done4), .pkt_err(pkt_err4), .good_cnt(good_cnt4), .bad_cnt(bad_cnt4)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    if (!CntEn) return 32'd0;
    return (v > mx) ? mx : v;
  endfunction

  // Scoreboard state
  beat_t      exp_q[$];
  beat_t      obs[$];
  int         exp_good = 0, exp_bad = 0, done_seen = 0, err_seen = 0, mon_len = 0;
  logic [7:0] mon_xor = 8'h00;
  bit         pend_done = 0, pend_err = 0, stall_q = 0;
  beat_t      stall_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs", {21'd0, s_tready, m_tvalid, m_tdata, m_tlast, m_tuser}, 32'd0);
      chk("rst_status", {30'd0, pkt_done, pkt_err}, 32'd0);
      chk("rst_cnt", {good_cnt, bad_cnt}, 32'd0);
      exp_q.delete();
      exp_good = 0; exp_bad = 0; mon_xor = 8'h00; mon_len = 0;
      pend_done = 0; pend_err = 0; stall_q = 0;
    end else begin
      chk("pkt_done", {31'd0, pkt_done}, {31'd0, pend_done});
      chk("pkt_err", {31'd0, pkt_err}, {31'd0, pend_err});
      if (pkt_done) done_seen++;
      if (pkt_err) err_seen++;
      chk("good_cnt", {16'd0, good_cnt}, cnt_exp(exp_good, 16));
      chk("bad_cnt", {16'd0, bad_cnt}, cnt_exp(exp_bad, 16));
      chk("good_cnt4", {28'd0, good_cnt4}, cnt_exp(exp_good, 4));
      chk("bad_cnt4", {28'd0, bad_cnt4}, cnt_exp(exp_bad, 4));
      if (stall_q) chk("stall_hold", {21'd0, m_tvalid, m_tdata, m_tlast, m_tuser},
                       {21'd0, 1'b1, stall_b});
      stall_q = m_tvalid && !m_tready;
      stall_b = '{d: m_tdata, l: m_tlast, u: m_tuser};
      if (m_tvalid && m_tready) begin
        obs.push_back('{d: m_tdata, l: m_tlast, u: m_tuser});
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_tdata);
        end else begin
          chk("m_beat", {22'd0, m_tdata, m_tlast, m_tuser}, {22'd0, exp_q.pop_front()});
        end
      end
      pend_done = 0; pend_err = 0;
      if (s_tvalid && s_tready) begin
        if (s_tlast) begin
          pend_done = 1;
          pend_err  = ((mon_xor ^ s_tdata) != 8'h00) || (mon_len == 0);
          if (pend_err) exp_bad++; else exp_good++;
          mon_xor = 8'h00; mon_len = 0;
        end else begin
          mon_xor ^= s_tdata; mon_len++;
        end
      end
    end
  end

  logic [7:0] pkt[$];

  task automatic wait_accept();
    int  k;
    bit  acc;
    k = 0; acc = 0;
    while (!acc) begin
      @(negedge clk);
      acc = s_tready;
      @(posedge clk); #1;
      k++;
      if (!acc && k > 200) begin
        checks++; failures++;
        $display("FAIL accept_timeout actual=stalled required=accepted");
        acc = 1;
      end
    end
  endtask

  // Sends pkt; n_send < pkt.size() aborts after n_send beats and expects nothing.
  task automatic send(input int n_send);
    logic [7:0] x;
    bit         bad;
    int         n;
    n = pkt.size();
    if (n_send == n) begin
      x = 8'h00;
      foreach (pkt[i]) x ^= pkt[i];
      bad = (x != 8'h00) || (n == 1);
      for (int i = 0; i < n - 1; i++)
        exp_q.push_back('{d: pkt[i], l: (i == n - 2), u: (i == n - 2) && bad});
    end
    for (int i = 0; i < n_send; i++) begin
      s_tvalid = 1'b1; s_tdata = pkt[i]; s_tlast = (i == n - 1);
      wait_accept();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk); #1; k++;
    end
    chk("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  int n0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("tready_before_edge", {31'd0, s_tready}, 32'd0);
    @(posedge clk); #1;
    chk("tready_after_edge", {31'd0, s_tready}, 32'd1);

    // Good packet
    pkt = '{8'h01, 8'h02, 8'h03}; send(3); drain();
    chk("p1_size", obs.size(), 32'd2);
    chk("p1_b0", {22'd0, obs[0]}, {22'd0, 8'h01, 1'b0, 1'b0});
    chk("p1_b1", {22'd0, obs[1]}, {22'd0, 8'h02, 1'b1, 1'b0});
    chk("p1_done", done_seen, 32'd1);
    chk("p1_good", {16'd0, good_cnt}, CntEn ? 32'd1 : 32'd0);

    // Bad parity
    pkt = '{8'h01, 8'h02, 8'h00}; send(3); drain();
    chk("p2_b1", {22'd0, obs[3]}, {22'd0, 8'h02, 1'b1, 1'b1});
    chk("p2_err", err_seen, 32'd1);
    chk("p2_bad", {16'd0, bad_cnt}, CntEn ? 32'd1 : 32'd0);

    // Runt
    pkt = '{8'h00}; send(1); drain();
    chk("runt_nobeat", obs.size(), 32'd4);
    chk("runt_done", done_seen, 32'd3);
    chk("runt_err", err_seen, 32'd2);
    chk("runt_bad", {16'd0, bad_cnt}, CntEn ? 32'd2 : 32'd0);

    // 20-byte packet with a 5-cycle master stall
    pkt.delete();
    for (int i = 1; i <= 19; i++) pkt.push_back(8'(i));
    pkt.push_back(8'h01 ^ 8'h02 ^ 8'h03 ^ 8'h04 ^ 8'h05 ^ 8'h06 ^ 8'h07 ^ 8'h08 ^ 8'h09 ^
                  8'h0a ^ 8'h0b ^ 8'h0c ^ 8'h0d ^ 8'h0e ^ 8'h0f ^ 8'h10 ^ 8'h11 ^ 8'h12 ^ 8'h13);
    n0 = obs.size();
    fork
      send(20);
      begin
        repeat (6) @(posedge clk);
        #1 m_tready = 1'b0;
        @(negedge clk);
        chk("stall_tready", {31'd0, s_tready}, 32'd0);
        repeat (5) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    drain();
    chk("long_count", obs.size() - n0, 32'd19);
    for (int k = 0; k < 19; k++)
      chk("long_order", {24'd0, obs[n0 + k].d}, k + 1);
    chk("long_good", {16'd0, good_cnt}, CntEn ? 32'd2 : 32'd0);

    // Reset mid-packet, then a fresh good packet
    pkt = '{8'hAA, 8'hBB, 8'hCC, 8'hDD}; send(2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_good", {16'd0, good_cnt}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n0 = obs.size();
    pkt = '{8'h05, 8'h06, 8'h03}; send(3); drain();
    chk("post_rst_count", obs.size() - n0, 32'd2);
    chk("post_rst_b0", {22'd0, obs[n0]}, {22'd0, 8'h05, 1'b0, 1'b0});
    chk("post_rst_b1", {22'd0, obs[n0 + 1]}, {22'd0, 8'h06, 1'b1, 1'b0});
    chk("post_rst_good", {16'd0, good_cnt}, CntEn ? 32'd1 : 32'd0);

    // Saturation of the 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      pkt = '{8'(i), 8'(i)}; send(2);
    end
    drain();
    chk("sat_good4", {28'd0, good_cnt4}, CntEn ? 32'd15 : 32'd0);
    chk("sat_good16", {16'd0, good_cnt}, CntEn ? 32'd18 : 32'd0);
    chk("sat_bad", {16'd0, bad_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/axis_parity_checker.md
AXIS_PARITY_CHECKER -- requirements
Module: axis_parity_checker

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of each status counter.
REQ-002 The block SHALL have port a_clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-003 The block SHALL have port axis_aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have slave inputs axis_s_tvalid (1), axis_s_tdata (8) and axis_s_tlast (1): the packet stream from parity_tester, whose last beat is the parity byte.
REQ-005 The block SHALL have output axis_s_tready, 1 bit: slave-side ready.
REQ-006 The block SHALL have master outputs axis_m_tvalid (1), axis_m_tdata (8), axis_m_tlast (1) and axis_m_tuser (1): the payload with the parity byte stripped; tuser is the error flag on the last beat.
REQ-007 The block SHALL have input axis_m_tready, 1 bit: master-side ready.
REQ-008 The block SHALL have outputs pkt_done (1) and pkt_err (1): single-cycle status pulses.
REQ-009 The block SHALL have outputs good_cnt and bad_cnt, CNT_W bits each: packet counters.

Function
REQ-010 The block SHALL treat a slave beat as accepted when axis_s_tvalid and axis_s_tready are both 1; a master beat SHALL be consumed when axis_m_tvalid and axis_m_tready are both 1.
REQ-011 The block SHALL use two states: IDLE, with the hold register empty, and HOLD, with one payload byte held.
REQ-012 In IDLE, an accepted non-last beat SHALL load the hold register and move the block to HOLD.
REQ-013 In IDLE, an accepted last beat SHALL be a runt packet: nothing forwarded; status is updated as an error; the state stays IDLE.
REQ-014 In HOLD, an accepted beat SHALL move the held byte to the output register, with axis_m_tlast equal to that beat's tlast.
REQ-015 In HOLD, a non-last accepted beat SHALL replace the held byte; a last accepted beat SHALL be dropped and the block SHALL return to IDLE.
REQ-016 axis_s_tready SHALL be 1 when state is IDLE, or axis_m_tvalid is 0, or axis_m_tready is 1; it is derived combinationally from registers and axis_m_tready.
REQ-017 The output register SHALL hold data, last and user stable while axis_m_tvalid=1 and axis_m_tready=0.
REQ-018 axis_m_tvalid SHALL drop after consumption unless the output register is reloaded in the same cycle.
REQ-019 Latency: payload byte k SHALL appear on the master port one cycle after byte k+1 is accepted.
REQ-020 A running XOR accumulator SHALL include every accepted byte of the packet, parity byte included, and SHALL clear to 0x00 after each last beat.
REQ-021 A packet SHALL be in error if the final XOR (accumulator ^ last byte) is non-zero or the packet is a runt.
REQ-022 On acceptance of each last beat, pkt_done SHALL pulse for 1 cycle, pkt_err SHALL pulse if the packet is in error, and axis_m_tuser of the forwarded last beat SHALL equal the error flag.
REQ-023 On acceptance of each last beat, good_cnt or bad_cnt SHALL increment by 1; both counters SHALL saturate at all-ones with no wrap.
REQ-024 axis_m_tuser SHALL be 0 on non-last beats.

Reset
REQ-025 While axis_aresetn=0, the block SHALL asynchronously force state=IDLE, accumulator=0x00 and the hold register empty.
REQ-026 While axis_aresetn=0, axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tuser, pkt_done, pkt_err, good_cnt and bad_cnt SHALL all be 0, and axis_s_tready SHALL be 0.
REQ-027 Reset release SHALL be honoured synchronously: axis_s_tready is first 1 in the cycle after axis_aresetn rises.
REQ-028 A reset asserted mid-packet SHALL discard the partial packet with no status update; the first beat after release SHALL start a new packet.

Configuration
REQ-029 With macro PARITY_CHECKER_COUNTERS_EN defined, good_cnt and bad_cnt SHALL be implemented per REQ-023.
REQ-030 Without PARITY_CHECKER_COUNTERS_EN, good_cnt and bad_cnt SHALL be constant 0 and no counter registers SHALL be inferred; pkt_done, pkt_err and tuser SHALL be unaffected.

Verification
REQ-031 Input 0x01,0x02,0x03(last) with m_tready=1 -> output 0x01, then 0x02 with tlast=1 and tuser=0; pkt_done pulses once; good_cnt=1.
REQ-032 Input 0x01,0x02,0x00(last) -> output 0x01, then 0x02 with tlast=1 and tuser=1; pkt_err pulses; bad_cnt=1.
REQ-033 Single beat 0x00(last) -> no master beat; pkt_done and pkt_err pulse; bad_cnt=1.
REQ-034 20-byte packet with m_tready held low for 5 cycles mid-stream -> s_tready drops while the output register is full; all 19 payload bytes arrive in order with no loss or duplication.
REQ-035 Reset asserted after 2 beats of a packet, then a 3-byte good packet -> counters and outputs read 0 during reset; afterwards only the new packet's 2 payload bytes are forwarded; good_cnt=1.
REQ-036 With CNT_W=4 and PARITY_CHECKER_COUNTERS_EN defined, send 17 good packets -> good_cnt saturates at 15.
REQ-037 With PARITY_CHECKER_COUNTERS_EN undefined, send 17 good packets -> good_cnt and bad_cnt stay 0.
